ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
// Hazard and sequencing controller for the 5-stage MIPS pipeline around the execute stage.
// Drives ALU operand forwarding selects, inserts load-use bubbles, and flushes on taken branch (resolved in MEM).
// Freezes the whole pipeline while data memory is busy.
// Keeps saturating stall/flush event counters and a sticky memory-timeout flag.
// PARAMETERS
// LOAD_STALLS  1   bubbles inserted per load-use hazard (1..7)
// MAX_WAIT     16  consecutive dmem_busy cycles before mem_timeout sets (2..255)
// CNT_W        16  width of stall_cnt / flush_cnt (saturating)
// PORTS
// clk            in   1      pipeline clock, rising edge
// rst_n          in   1      asynchronous active-low reset
// id_rs,id_rt    in   5      source regs of instruction in IF/ID
// id_uses_rs/rt  in   1      instruction in IF/ID reads rs / rt
// idex_rs,idex_rt in  5      source regs of instruction in ID/EX
// idex_memread   in   1      ID/EX instruction is a load
// idex_dst       in   5      ID/EX destination (regdst mux output)
// exmem_regwrite in   1      EX/MEM writes a register
// exmem_dst      in   5      EX/MEM destination
// memwb_regwrite in   1      MEM/WB writes a register
// memwb_dst      in   5      MEM/WB destination
// branch_taken   in   1      MEM-stage branch taken (PCSrc)
// dmem_busy      in   1      data memory not ready this cycle
// fwd_a,fwd_b    out  2      ALU A/B select: 00 regfile, 10 EX/MEM, 01 MEM/WB
// pc_write       out  1      PC may update
// ifid_write     out  1      IF/ID may load
// ifid_flush     out  1      zero IF/ID
// idex_bubble    out  1      load NOP controls into ID/EX
// exmem_flush    out  1      zero EX/MEM ctlwb/ctlm
// pipe_freeze    out  1      hold ID/EX, EX/MEM, MEM/WB
// stall_cnt      out  CNT_W  cycles with pc_write=0 (saturates)
// flush_cnt      out  CNT_W  branch flushes issued (saturates)
// mem_timeout    out  1      sticky; cleared only by reset
// BEHAVIOUR
// Reset (rst_n=0, async): state=RUN, lu_cnt=0, wait_cnt=0, counters=0, mem_timeout=0.
//   While in reset all control outputs forced to 0; fwd_a/fwd_b=00.
// Forwarding, combinational, any state:
//   fwd_a=10 if exmem_regwrite && exmem_dst!=0 && exmem_dst==idex_rs.
//   Else fwd_a=01 if memwb_regwrite && memwb_dst!=0 && memwb_dst==idex_rs.
//   Else fwd_a=00. fwd_b is identical using idex_rt. EX/MEM has priority.
// lu_hz = idex_memread && idex_dst!=0 && ((id_uses_rs&&idex_dst==id_rs)||(id_uses_rt&&idex_dst==id_rt)).
// Default outputs: pc_write=ifid_write=1; all flush/bubble/freeze outputs 0.
// Outputs are Mealy (same cycle as cause). Priority each cycle: dmem_busy > branch_taken > load-use.
// FSM states: RUN, LU_STALL, MEM_WAIT.
// RUN:
//   dmem_busy: pc_write=ifid_write=0, pipe_freeze=1; ret<=RUN; wait_cnt<=1; ->MEM_WAIT.
//   elif branch_taken: ifid_flush=idex_bubble=exmem_flush=1, pc_write=1; flush_cnt++; stay RUN.
//   elif lu_hz: pc_write=ifid_write=0, idex_bubble=1.
//     If LOAD_STALLS>1: lu_cnt<=LOAD_STALLS-1, ->LU_STALL. Else stay RUN.
// LU_STALL: pc_write=ifid_write=0, idex_bubble=1; lu_cnt--; ->RUN when lu_cnt==1.
//   dmem_busy: freeze as in RUN, lu_cnt held, ret<=LU_STALL, ->MEM_WAIT.
//   branch_taken (no busy): flush as in RUN, abandon stall, ->RUN.
// MEM_WAIT:
//   dmem_busy=1: freeze; wait_cnt saturates at MAX_WAIT; mem_timeout<=1 when wait_cnt==MAX_WAIT-1.
//   dmem_busy=0: evaluate that cycle exactly as state ret, including its transitions; wait_cnt<=0.
// stall_cnt++ on every cycle with pc_write=0. flush_cnt counts flush cycles. Both saturate at all-ones.
// Asserting rst_n mid-stall/wait aborts the sequence; the first cycle after release is RUN.
// TESTING
// T1 exmem_regwrite=1,exmem_dst=10,memwb_regwrite=1,memwb_dst=10,idex_rs=10 -> fwd_a=10; exmem_dst=0 -> fwd_a=01.
// T2 LOAD_STALLS=1: idex_memread=1,idex_dst=5,id_rs=5,id_uses_rs=1 -> 1 cycle pc_write=0,idex_bubble=1; stall_cnt=1.
// T3 LOAD_STALLS=2 same stimulus, idex_memread drops next cycle -> 2 bubble cycles, then pc_write=1; stall_cnt=2.
// T4 branch_taken=1 in 1st LU_STALL cycle (LOAD_STALLS=3) -> ifid_flush=idex_bubble=exmem_flush=1, pc_write=1, RUN; flush_cnt=1.
// T5 dmem_busy 3 cycles in RUN -> pipe_freeze=1,pc_write=0 for 3 cycles, normal on 4th; stall_cnt=3; mem_timeout=0.
// T6 MAX_WAIT=4, dmem_busy 6 cycles -> mem_timeout=1 after 4th busy cycle, stays 1.
//    Then rst_n=0 mid-wait -> all outputs/counters 0; first cycle after release is RUN.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// ============================================================================
// Module   : ex_hazard_ctrl
// Purpose  : Forwarding selects, load-use bubbles, branch flush, memory freeze
//            and event counters for a 5-stage MIPS execute stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_hazard_ctrl #(
  parameter int LOAD_STALLS = 1,
  parameter int MAX_WAIT    = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_dst,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_dst,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_dst,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] c_lu_init     = 3'(LOAD_STALLS - 1);
  localparam logic [7:0] c_max_wait    = 8'(MAX_WAIT);
  localparam logic [7:0] c_max_wait_m1 = 8'(MAX_WAIT - 1);

  state_t           r_state, r_ret;
  logic [2:0]       r_lu_cnt;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             r_mem_timeout;

  state_t     w_state_n, w_ret_n, w_eval;
  logic [2:0] w_lu_n;
  logic [7:0] w_wait_n;
  logic       w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble;
  logic       w_exmem_flush, w_pipe_freeze, w_timeout_set, w_lu_hz;
  logic [1:0] w_fwd_a, w_fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (exmem_regwrite && exmem_dst != 5'd0 && exmem_dst == src)
      return 2'b10;
    else if (memwb_regwrite && memwb_dst != 5'd0 && memwb_dst == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_fwd_a = fwd_sel(idex_rs);
  assign w_fwd_b = fwd_sel(idex_rt);
  assign w_lu_hz = idex_memread && idex_dst != 5'd0 &&
                   ((id_uses_rs && idex_dst == id_rs) || (id_uses_rt && idex_dst == id_rt));

  // Leaving MEM_WAIT replays the interrupted state in the same cycle.
  assign w_eval = (r_state == MEM_WAIT) ? r_ret : r_state;

  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exmem_flush = 1'b0;
    w_pipe_freeze = 1'b0;
    w_timeout_set = 1'b0;
    w_state_n     = r_state;
    w_ret_n       = r_ret;
    w_lu_n        = r_lu_cnt;
    w_wait_n      = r_wait_cnt;
    if (dmem_busy) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_pipe_freeze = 1'b1;
      if (r_state == MEM_WAIT) begin
        if (r_wait_cnt != c_max_wait) w_wait_n = r_wait_cnt + 8'd1;
        if (r_wait_cnt == c_max_wait_m1) w_timeout_set = 1'b1;
      end else begin
        w_ret_n   = r_state;
        w_wait_n  = 8'd1;
        w_state_n = MEM_WAIT;
      end
    end else begin
      w_wait_n  = 8'd0;
      w_state_n = w_eval;
      if (branch_taken) begin
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        w_exmem_flush = 1'b1;
        w_lu_n        = 3'd0;
        w_state_n     = RUN;
      end else if (w_eval == LU_STALL) begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_bubble = 1'b1;
        w_lu_n        = r_lu_cnt - 3'd1;
        if (r_lu_cnt == 3'd1) w_state_n = RUN;
      end else if (w_lu_hz) begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_bubble = 1'b1;
        if (LOAD_STALLS > 1) begin
          w_lu_n    = c_lu_init;
          w_state_n = LU_STALL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_ret         <= RUN;
      r_lu_cnt      <= 3'd0;
      r_wait_cnt    <= 8'd0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_ret      <= w_ret_n;
      r_lu_cnt   <= w_lu_n;
      r_wait_cnt <= w_wait_n;
      if (!w_pc_write && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_exmem_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_timeout_set) r_mem_timeout <= 1'b1;
    end
  end

  // Control outputs are held inactive for the whole time reset is asserted.
  assign fwd_a       = rst_n ? w_fwd_a : 2'b00;
  assign fwd_b       = rst_n ? w_fwd_b : 2'b00;
  assign pc_write    = rst_n & w_pc_write;
  assign ifid_write  = rst_n & w_ifid_write;
  assign ifid_flush  = rst_n & w_ifid_flush;
  assign idex_bubble = rst_n & w_idex_bubble;
  assign exmem_flush = rst_n & w_exmem_flush;
  assign pipe_freeze = rst_n & w_pipe_freeze;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_timeout = r_mem_timeout;

endmodule

`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
// ============================================================================
// Module   : tb_ex_hazard_ctrl
// Purpose  : Directed checks of ex_hazard_ctrl with LOAD_STALLS = 1, 2, 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, idex_rs, idex_rt, idex_dst, exmem_dst, memwb_dst;
  logic       id_uses_rs, id_uses_rt, idex_memread, exmem_regwrite, memwb_regwrite;
  logic       branch_taken, dmem_busy;

  logic [2:0]       pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [2:0]       exmem_flush, pipe_freeze, mem_timeout;
  logic [2:0][1:0]  fwd_a, fwd_b;
  logic [2:0][15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instance g has LOAD_STALLS = g+1; all share the same stimulus.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ex_hazard_ctrl #(.LOAD_STALLS(g + 1), .MAX_WAIT(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_memread(idex_memread), .idex_dst(idex_dst),
      .exmem_regwrite(exmem_regwrite), .exmem_dst(exmem_dst),
      .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst),
      .branch_taken(branch_taken), .dmem_busy(dmem_busy),
      .fwd_a(fwd_a[g]), .fwd_b(fwd_b[g]),
      .pc_write(pc_write[g]), .ifid_write(ifid_write[g]), .ifid_flush(ifid_flush[g]),
      .idex_bubble(idex_bubble[g]), .exmem_flush(exmem_flush[g]), .pipe_freeze(pipe_freeze[g]),
      .stall_cnt(stall_cnt[g]), .flush_cnt(flush_cnt[g]), .mem_timeout(mem_timeout[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    idex_rs = 0; idex_rt = 0; idex_memread = 0; idex_dst = 0;
    exmem_regwrite = 0; exmem_dst = 0; memwb_regwrite = 0; memwb_dst = 0;
    branch_taken = 0; dmem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    idex_memread = 1; idex_dst = 5; id_rs = 5; id_uses_rs = 1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    // Forwarding condition active during reset must still yield 00.
    exmem_regwrite = 1; exmem_dst = 10; idex_rs = 10;
    #12;
    chk("rst_fwd_a", fwd_a[0], 2'b00);
    chk("rst_pc_write", pc_write, 3'b000);
    chk("rst_stall_cnt", stall_cnt[0], 0);
    chk("rst_timeout", mem_timeout[0], 0);
    rst_n = 1;
    #1;
    chk("run_pc_write", pc_write, 3'b111);

    // Forwarding priority and zero-register exclusion
    memwb_regwrite = 1; memwb_dst = 10; idex_rt = 10; #1;
    chk("fwd_a_exmem", fwd_a[0], 2'b10);
    chk("fwd_b_exmem", fwd_b[0], 2'b10);
    exmem_dst = 0; #1;
    chk("fwd_a_memwb", fwd_a[0], 2'b01);
    idex_rt = 11; #1;
    chk("fwd_b_none", fwd_b[0], 2'b00);
    memwb_dst = 0; #1;
    chk("fwd_a_r0", fwd_a[0], 2'b00);
    clear_inputs();
    tick();

    // Load-use with 1, 2, 3 bubbles
    load_use(); #1;
    chk("lu_c1_pc_write", pc_write, 3'b000);
    chk("lu_c1_bubble", idex_bubble, 3'b111);
    tick();
    clear_inputs(); #1;
    chk("lu_c2_pc_write", pc_write, 3'b001);
    chk("lu_c2_bubble", idex_bubble, 3'b110);
    chk("ls1_stall_cnt", stall_cnt[0], 1);
    tick();
    chk("lu_c3_pc_write", pc_write, 3'b011);
    chk("ls2_stall_cnt", stall_cnt[1], 2);
    tick();
    chk("lu_c4_pc_write", pc_write, 3'b111);
    chk("ls3_stall_cnt", stall_cnt[2], 3);

    // Branch in first LU_STALL cycle abandons the stall
    load_use(); tick();
    clear_inputs(); branch_taken = 1; #1;
    chk("br_pc_write", pc_write[2], 1);
    chk("br_ifid_flush", ifid_flush[2], 1);
    chk("br_bubble", idex_bubble[2], 1);
    chk("br_exmem_flush", exmem_flush[2], 1);
    tick();
    branch_taken = 0; #1;
    chk("br_after_pc_write", pc_write[2], 1);
    chk("br_flush_cnt", flush_cnt[2], 1);
    chk("br_stall_cnt", stall_cnt[2], 4);
    tick();

    // dmem_busy for 3 cycles; branch during busy must not flush
    dmem_busy = 1; branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_freeze", pipe_freeze[0], 1);
      chk("busy_pc_write", pc_write[0], 0);
      chk("busy_no_flush", ifid_flush[0], 0);
      tick();
      branch_taken = 0;
    end
    dmem_busy = 0; #1;
    chk("busy_end_freeze", pipe_freeze[0], 0);
    chk("busy_end_pc_write", pc_write[0], 1);
    chk("busy_stall_cnt", stall_cnt[0], 5);
    chk("busy_flush_cnt", flush_cnt[0], 1);
    chk("busy_timeout", mem_timeout[0], 0);
    tick();

    // Six busy cycles with MAX_WAIT=4: timeout sets after the fourth
    dmem_busy = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("timeout_c%0d", i), mem_timeout[0], (i >= 4) ? 1 : 0);
    end

    // Reset mid-wait
    rst_n = 0; #1;
    chk("midrst_freeze", pipe_freeze, 3'b000);
    chk("midrst_pc_write", pc_write, 3'b000);
    chk("midrst_stall_cnt", stall_cnt[0], 0);
    chk("midrst_flush_cnt", flush_cnt[0], 0);
    chk("midrst_timeout", mem_timeout[0], 0);
    dmem_busy = 0;
    tick();
    rst_n = 1; #1;
    chk("post_rst_pc_write", pc_write, 3'b111);
    chk("post_rst_ifid_write", ifid_write, 3'b111);
    tick();
    chk("post_rst_stall_cnt", stall_cnt[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
